// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin arbiter letting requesters a and b share one single-port RAM, plus a whole-RAM clear.
// Latency: write ack 2 cycles after the grant edge, read ack 3, clr_done 2 after the clear starts; all outputs registered.
// Backpressure: requesters hold x_req until x_ack; a clr_req seen during an access is remembered until the access ends.
// Ports: a_*/b_* request side (req/we/addr/wdata in, ack/rdata out), clr_req in / clr_done out, busy out,
//        RAM side ram_rst/ram_we/ram_addr/ram_din out and ram_dout in (registered read, one-edge latency).
module ram_arbiter #(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_ack,
    output logic [DW-1:0] a_rdata,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_ack,
    output logic [DW-1:0] b_rdata,
    input  logic          clr_req,
    output logic          clr_done,
    output logic          busy,
    output logic          ram_rst,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    typedef enum logic [1:0] {IDLE, ACCESS, RDWAIT, CLEAR} state_t;

    state_t state;
    logic   ptr;       // 1: b wins the next tie, 0: a wins
    logic   owner;     // requester of the access in flight, 1 = b
    logic   clr_pend;  // clear requested while an access was in flight

    logic a_elig;
    logic b_elig;
    logic pick_b;
    logic clr_want;

    // A requester still holds x_req during its own ack cycle; it must not be granted again off that stale level.
    assign a_elig   = a_req & ~a_ack;
    assign b_elig   = b_req & ~b_ack;
    assign pick_b   = b_elig & (~a_elig | ptr);
    // Same idea for a clear request still high in the clr_done cycle.
    assign clr_want = clr_pend | (clr_req & ~clr_done);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            ptr      <= 1'b0;
            owner    <= 1'b0;
            clr_pend <= 1'b0;
            a_ack    <= 1'b0;
            b_ack    <= 1'b0;
            a_rdata  <= '0;
            b_rdata  <= '0;
            clr_done <= 1'b0;
            busy     <= 1'b0;
            ram_rst  <= 1'b0;
            ram_we   <= 1'b0;
            ram_addr <= '0;
            ram_din  <= '0;
        end else begin
            // Pulsed outputs default low; each is raised for a single cycle below.
            a_ack    <= 1'b0;
            b_ack    <= 1'b0;
            clr_done <= 1'b0;
            ram_rst  <= 1'b0;
            ram_we   <= 1'b0;

            case (state)
                IDLE: begin
                    if (clr_want) begin
                        state    <= CLEAR;
                        busy     <= 1'b1;
                        ram_rst  <= 1'b1;
                        clr_pend <= 1'b0;
                    end else if (a_elig || b_elig) begin
                        state    <= ACCESS;
                        busy     <= 1'b1;
                        owner    <= pick_b;
                        ptr      <= ~pick_b;
                        ram_we   <= pick_b ? b_we    : a_we;
                        ram_addr <= pick_b ? b_addr  : a_addr;
                        ram_din  <= pick_b ? b_wdata : a_wdata;
                    end
                end

                ACCESS: begin
                    if (clr_req) clr_pend <= 1'b1;
                    // ram_we is the registered copy of the winner's x_we, so it tells read from write here.
                    if (ram_we) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        a_ack <= ~owner;
                        b_ack <= owner;
                    end else begin
                        state <= RDWAIT;
                    end
                end

                RDWAIT: begin
                    if (clr_req) clr_pend <= 1'b1;
                    state <= IDLE;
                    busy  <= 1'b0;
                    a_ack <= ~owner;
                    b_ack <= owner;
                    if (owner) b_rdata <= ram_dout;
                    else       a_rdata <= ram_dout;
                end

                CLEAR: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    clr_done <= 1'b1;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter AW, default 4, RAM address width in bits (16 words).
REQ-002 Parameter DW, default 8, RAM data width in bits.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset; asserted at 0.
REQ-005 x_req  input  1  (x = a, b) access request, held high until x_ack.
REQ-006 x_we  input  1  (x = a, b) 1 = write, 0 = read; held stable while x_req is high.
REQ-007 x_addr  input  AW  (x = a, b) word address; held stable while x_req is high.
REQ-008 x_wdata  input  DW  (x = a, b) write data; held stable while x_req is high.
REQ-009 x_ack  output  1  (x = a, b) one-cycle completion pulse.
REQ-010 x_rdata  output  DW  (x = a, b) read data, valid in the x_ack cycle of a read and held until the next read completion for x.
REQ-011 clr_req  input  1  request to clear the whole RAM.
REQ-012 clr_done  output  1  one-cycle pulse when the clear completes.
REQ-013 busy  output  1  high whenever the state is not IDLE.
REQ-014 ram_rst  output  1  drives the RAM synchronous active-high clear.
REQ-015 ram_we  output  1  drives the RAM write enable.
REQ-016 ram_addr  output  AW  drives the RAM address.
REQ-017 ram_din  output  DW  drives the RAM write data.
REQ-018 ram_dout  input  DW  RAM registered read data (one-edge latency, updates only when ram_we = 0).

Function
REQ-019 All outputs SHALL be registered; the FSM SHALL have states IDLE, ACCESS, RDWAIT and CLEAR.
REQ-020 IDLE: clr_req high -> CLEAR (priority over a_req and b_req); else any eligible request -> ACCESS.
REQ-021 A requester SHALL be ineligible in IDLE during the cycle its own x_ack is high.
REQ-022 Arbitration SHALL be round-robin: on simultaneous eligible requests, grant the requester not granted last; a single eligible requester is granted at once.
REQ-023 On grant, ram_addr, ram_din and ram_we SHALL be loaded from the winner at that edge, and the pointer SHALL move to the other requester.
REQ-024 ACCESS, write: ram_we = 1 for exactly this cycle; next edge -> IDLE with x_ack = 1; ack visible 2 cycles after grant edge.
REQ-025 ACCESS, read: ram_we = 0; next edge -> RDWAIT.
REQ-026 RDWAIT: next edge captures ram_dout into x_rdata, pulses x_ack and returns to IDLE; read ack visible 3 cycles after grant edge.
REQ-027 ram_we SHALL be 0 in every state other than ACCESS-for-write.
REQ-028 CLEAR: ram_rst = 1 for exactly one cycle; next edge -> IDLE with clr_done = 1.
REQ-029 clr_req arriving during ACCESS/RDWAIT SHALL wait; the in-flight access completes first.
REQ-030 Requests arriving while busy SHALL wait; none SHALL be dropped or duplicated.
REQ-031 Addresses SHALL be used unmodified; no wrap or range check (all 2^AW addresses valid).

Reset
REQ-032 rst = 0 SHALL immediately force: state IDLE; ram_rst, ram_we, ram_addr, ram_din, x_ack, x_rdata, clr_done, busy all 0; round-robin pointer to a.
REQ-033 A reset during ACCESS or RDWAIT SHALL abort the access with no ack; RAM contents are then undefined to the requester.

Verification
REQ-034 a writes addr 3 = 0x5A, then reads addr 3 -> a_ack 2 cycles after write grant; a_rdata = 0x5A with a_ack 3 cycles after read grant.
REQ-035 a and b request on the same edge after reset (a write addr 1 = 0x11, b write addr 2 = 0x22) -> a served first, b next; both acked once; readback 0x11 and 0x22.
REQ-036 a and b hold continuous requests for 8 grants -> grants alternate a, b, a, b, ... with no double grant.
REQ-037 Fill all 16 addresses, pulse clr_req together with a_req -> CLEAR first, ram_rst high one cycle, clr_done pulses; subsequent reads of addr 0-15 return 0x00.
REQ-038 Assert rst = 0 mid-read (RDWAIT) -> outputs 0 at once, no a_ack; after release a fresh request completes normally.
